// File: rtl/wb_host_initiator.sv
// rtl/wb_host_initiator.sv - Wishbone classic single-transfer initiator with bounded ack timeout
module wb_host_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic [7:0]  err_count_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value seen on the last wait edge before the cycle is abandoned.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_dat_q, rsp_dat_d;
   logic             rsp_err_q, rsp_err_d;
   logic             cyc_q, cyc_d;
   logic             stb_q, stb_d;
   logic             we_q, we_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic [3:0]       sel_q, sel_d;
   logic [7:0]       err_count_q, err_count_d;

   // Next-state and next-output logic for the IDLE -> BUS -> RESP transfer sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      err_count_d = err_count_q;

      case (state_q)
         ST_IDLE: begin
            // Ready rises on the first edge after reset release, not during reset.
            cmd_ready_d = 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               we_d        = cmd_we_i;
               adr_d       = cmd_adr_i;
               dat_d       = cmd_dat_i;
               sel_d       = cmd_sel_i;
               cnt_d       = '0;
               state_d     = ST_BUS;
            end
         end

         ST_BUS: begin
            // Ack is checked first so an ack on the timeout edge still completes cleanly.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state and outputs registered; reset aborts any open bus cycle immediately.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= 32'h0;
         rsp_err_q   <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= 32'h0;
         dat_q       <= 32'h0;
         sel_q       <= 4'h0;
         err_count_q <= 8'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         err_count_q <= err_count_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign wbm_sel_o   = sel_q;
   assign err_count_o = err_count_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
// tb/tb_wb_host_initiator.sv - directed self-checking bench for wb_host_initiator
module tb_wb_host_initiator;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc;
   logic        wbm_stb;
   logic        wbm_we;
   logic [31:0] wbm_adr;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel;
   logic        wbm_ack;
   logic [31:0] wbm_dat_i;
   logic [7:0]  err_count;

   // Slave model: either a zero-wait slave (ack follows stb) or a hand-driven ack.
   logic        zero_wait;
   logic        ack_man;
   assign wbm_ack = zero_wait ? wbm_stb : ack_man;

   int checks = 0;
   int errors = 0;

   wb_host_initiator #(.TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .cmd_sel_i   (cmd_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (wbm_cyc),
      .wbm_stb_o   (wbm_stb),
      .wbm_we_o    (wbm_we),
      .wbm_adr_o   (wbm_adr),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_sel_o   (wbm_sel),
      .wbm_ack_i   (wbm_ack),
      .wbm_dat_i   (wbm_dat_i),
      .err_count_o (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // One write command that the slave never acks; returns after the response is consumed.
   task automatic do_timeout(output bit seen);
      int n;
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      seen = rsp_valid;
      consume();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_dat;
      int          stb_cycles;
      int          exp_err;
      bit          seen;
      bit          all_seen;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h0;
      cmd_dat   = 32'h0;
      cmd_sel   = 4'h0;
      rsp_ready = 1'b0;
      zero_wait = 1'b0;
      ack_man   = 1'b0;
      wbm_dat_i = 32'h0;

      // Reset state
      tick();
      tick();
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_cyc",       {31'b0, wbm_cyc},   32'd0);
      check("rst_stb",       {31'b0, wbm_stb},   32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_err_count", {24'b0, err_count}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // Write, slave acks after two wait states; slave data must not leak into rsp_dat
      wbm_dat_i = 32'hDEAD_BEEF;
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_adr   = 32'h3000_0004;
      cmd_dat   = 32'h0000_00FF;
      cmd_sel   = 4'hF;
      tick();
      cmd_valid = 1'b0;
      check("wr_stb1",      {31'b0, wbm_stb},   32'd1);
      check("wr_cyc",       {31'b0, wbm_cyc},   32'd1);
      check("wr_we",        {31'b0, wbm_we},    32'd1);
      check("wr_adr",       wbm_adr,            32'h3000_0004);
      check("wr_dat",       wbm_dat_o,          32'h0000_00FF);
      check("wr_sel",       {28'b0, wbm_sel},   32'hF);
      check("wr_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      tick();
      check("wr_stb2", {31'b0, wbm_stb}, 32'd1);
      tick();
      check("wr_stb3", {31'b0, wbm_stb}, 32'd1);
      check("wr_adr3", wbm_adr,          32'h3000_0004);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      check("wr_stb_done", {31'b0, wbm_stb},   32'd0);
      check("wr_cyc_done", {31'b0, wbm_cyc},   32'd0);
      check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("wr_rsp_err",  {31'b0, rsp_err},   32'd0);
      check("wr_rsp_dat",  rsp_dat,            32'h0);
      consume();
      check("wr_rsp_cleared", {31'b0, rsp_valid}, 32'd0);
      check("wr_ready_back",  {31'b0, cmd_ready}, 32'd1);

      // Read from a zero-wait slave
      zero_wait = 1'b1;
      wbm_dat_i = 32'hCAFE_1234;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h3000_0000;
      tick();
      cmd_valid = 1'b0;
      check("rd_stb",  {31'b0, wbm_stb}, 32'd1);
      check("rd_we",   {31'b0, wbm_we},  32'd0);
      check("rd_adr",  wbm_adr,          32'h3000_0000);
      tick();
      check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rd_rsp_dat",   rsp_dat,            32'hCAFE_1234);
      check("rd_rsp_err",   {31'b0, rsp_err},   32'd0);
      check("rd_stb_done",  {31'b0, wbm_stb},   32'd0);
      check("rd_we_done",   {31'b0, wbm_we},    32'd0);
      zero_wait = 1'b0;
      consume();

      // Timeout on a read: stb high for exactly 4 cycles
      wbm_dat_i = 32'h5555_AAAA;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      tick();
      cmd_valid  = 1'b0;
      stb_cycles = 0;
      for (int i = 0; i < 20 && wbm_stb; i++) begin
         stb_cycles++;
         tick();
      end
      check("to_stb_cycles", stb_cycles,         32'd4);
      check("to_rsp_valid",  {31'b0, rsp_valid}, 32'd1);
      check("to_rsp_err",    {31'b0, rsp_err},   32'd1);
      check("to_rsp_dat",    rsp_dat,            32'h0);
      check("to_err_count",  {24'b0, err_count}, 32'd1);
      consume();

      // Ack arriving on the timeout edge wins
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      wbm_dat_i = 32'h0BAD_F00D;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      check("race_stb_still", {31'b0, wbm_stb}, 32'd1);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      check("race_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("race_rsp_err",   {31'b0, rsp_err},   32'd0);
      check("race_rsp_dat",   rsp_dat,            32'h0BAD_F00D);
      check("race_err_count", {24'b0, err_count}, 32'd1);
      consume();

      // Response backpressure with a pending command
      zero_wait = 1'b1;
      wbm_dat_i = 32'h1357_9BDF;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h3000_0008;
      tick();
      tick();
      wbm_dat_i = 32'h2468_ACE0;
      held_dat  = 32'h1357_9BDF;
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_rsp_dat",   rsp_dat,            held_dat);
         check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         check("bp_cyc",       {31'b0, wbm_cyc},   32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_rel_ready", {31'b0, cmd_ready}, 32'd1);
      check("bp_rel_cyc",   {31'b0, wbm_cyc},   32'd0);
      check("bp_rel_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
      cmd_valid = 1'b0;
      check("bp_next_cyc", {31'b0, wbm_cyc}, 32'd1);
      tick();
      check("bp_next_dat", rsp_dat, 32'h2468_ACE0);
      zero_wait = 1'b0;
      consume();

      // Saturating error counter: 300 timeouts in total
      exp_err  = 1;
      all_seen = 1'b1;
      for (int i = 0; i < 299; i++) begin
         do_timeout(seen);
         if (!seen) all_seen = 1'b0;
         if (exp_err < 255) exp_err++;
         if (exp_err == 254 && i < 298) begin
            check("sat_err_254", {24'b0, err_count}, 32'd254);
         end
      end
      check("sat_all_responded", {31'b0, all_seen}, 32'd1);
      check("sat_err_255",       {24'b0, err_count}, 32'd255);

      // Reset asserted mid-bus-cycle acts immediately
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("mid_stb_open", {31'b0, wbm_stb}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_cyc",       {31'b0, wbm_cyc},   32'd0);
      check("mid_rst_stb",       {31'b0, wbm_stb},   32'd0);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("mid_rst_err_count", {24'b0, err_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      tick();
      check("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("stray_cyc",       {31'b0, wbm_cyc},   32'd0);
      check("stray_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // Still idle and usable after the stray ack
      zero_wait = 1'b1;
      wbm_dat_i = 32'h0000_ABCD;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("post_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("post_rsp_dat",   rsp_dat,            32'h0000_ABCD);
      zero_wait = 1'b0;
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
